// File: rtl/swc_rtu_rsp_source.sv
// swc_rtu_rsp_source
// Per-port RTU response source: a small show-ahead FIFO of forwarding
// decisions (destination mask, drop flag, priority) presented to one port of
// the switch core with a valid/ack handshake. Decisions with drop set or an
// empty destination mask are normalised to "drop, no destinations" on entry.
module swc_rtu_rsp_source #(
  parameter int g_num_ports  = 7,
  parameter int g_prio_width = 3,
  parameter int g_fifo_depth = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            req_valid_i,
  input  logic [g_num_ports-1:0]          req_mask_i,
  input  logic                            req_drop_i,
  input  logic [g_prio_width-1:0]         req_prio_i,
  output logic                            req_full_o,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ack_i,
  output logic [g_num_ports-1:0]          rsp_dst_port_mask_o,
  output logic                            rsp_drop_o,
  output logic [g_prio_width-1:0]         rsp_prio_o,
  output logic [$clog2(g_fifo_depth):0]   count_o,
  output logic                            ovf_o,
  input  logic                            ovf_clr_i
);

  localparam int unsigned AW = $clog2(g_fifo_depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(g_fifo_depth);

  logic [g_num_ports-1:0]  mem_mask [g_fifo_depth];
  logic                    mem_drop [g_fifo_depth];
  logic [g_prio_width-1:0] mem_prio [g_fifo_depth];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic                   full;
  logic                   empty;
  logic                   push_ok;
  logic                   push_rej;
  logic                   pop;
  logic [g_num_ports-1:0] wr_mask;
  logic                   wr_drop;

  // Handshake qualification and write-side normalisation
  always_comb begin
    full     = (count == DEPTH_C);
    empty    = (count == '0);
    push_ok  = req_valid_i && !full;
    push_rej = req_valid_i && full;
    pop      = rsp_ack_i && !empty;
    wr_mask  = req_drop_i ? '0 : req_mask_i;
    wr_drop  = req_drop_i || (req_mask_i == '0);
  end

  // Entry storage; cleared on reset so the head data reads zero when empty
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_mask <= '{default: '0};
      mem_drop <= '{default: 1'b0};
      mem_prio <= '{default: '0};
    end else if (push_ok) begin
      mem_mask[wr_ptr] <= wr_mask;
      mem_drop[wr_ptr] <= wr_drop;
      mem_prio[wr_ptr] <= req_prio_i;
    end
  end

  // Pointers and occupancy; full/empty come from count, not pointer compare
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a rejected push beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       ovf <= 1'b0;
    else if (push_rej)  ovf <= 1'b1;
    else if (ovf_clr_i) ovf <= 1'b0;
  end

  // Show-ahead head and status outputs
  always_comb begin
    rsp_valid_o         = !empty;
    rsp_dst_port_mask_o = mem_mask[rd_ptr];
    rsp_drop_o          = mem_drop[rd_ptr];
    rsp_prio_o          = mem_prio[rd_ptr];
    req_full_o          = full;
    count_o             = count;
    ovf_o               = ovf;
  end

endmodule

// File: doc/swc_rtu_rsp_source.md
# swc_rtu_rsp_source

Per-port RTU response source for the switch core: buffers forwarding decisions (destination port mask, drop flag, priority) and presents them to one port of the switch core's RTU response input with a valid/ack handshake. One instance drives one port's `rtu_rsp_valid_i` / `rtu_rsp_ack_o` / `rtu_dst_port_mask_i` / `rtu_drop_i` / `rtu_prio_i` slice. It decouples the decision producer (RTU or testbench model) from the switch core's acknowledge timing.

## Interface

**Parameters**
- `g_num_ports`, default 7: switch port count; width of the destination mask.
- `g_prio_width`, default 3: priority field width.
- `g_fifo_depth`, default 4: response entries buffered; power of 2, at least 2.

**Ports**
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: push one decision this cycle.
- `req_mask_i` in `g_num_ports`: destination port mask of the pushed decision.
- `req_drop_i` in 1: drop flag of the pushed decision.
- `req_prio_i` in `g_prio_width`: priority of the pushed decision.
- `req_full_o` out 1: FIFO full; pushes are rejected this cycle.
- `rsp_valid_o` out 1: head entry valid, to the core's `rtu_rsp_valid_i` bit.
- `rsp_ack_i` in 1: core acknowledge, from the core's `rtu_rsp_ack_o` bit.
- `rsp_dst_port_mask_o` out `g_num_ports`: head mask.
- `rsp_drop_o` out 1: head drop flag.
- `rsp_prio_o` out `g_prio_width`: head priority.
- `count_o` out `clog2(g_fifo_depth)+1`: current occupancy.
- `ovf_o` out 1: sticky overflow flag.
- `ovf_clr_i` in 1: clears `ovf_o`.

## Operation

- **Storage.** Register-array FIFO with show-ahead output.
  - `rd_ptr` and `wr_ptr` are `clog2(g_fifo_depth)` bits wide and wrap modulo depth.
  - `count` is a separate register in the range 0..`g_fifo_depth`.
- **Push.**
  - A push is accepted when `req_valid_i`=1 and `count` < `g_fifo_depth`, with `count` taken from the register before this cycle's pop.
  - An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
- **Push normalisation, applied at write time.**
  - `req_drop_i`=1: the stored mask is forced to all zeros and stored drop is 1.
  - `req_drop_i`=0 with `req_mask_i`=0: stored drop is forced to 1 (no destination).
  - Otherwise mask, drop and prio are stored unchanged.
- **Rejected push.** `req_valid_i`=1 while full (including full with a same-cycle ack):
  - the entry is discarded;
  - `ovf_o` is set on the next edge;
  - `count` and `wr_ptr` are unchanged by the push.
- **Pop.**
  - A pop occurs when `rsp_ack_i`=1 and `rsp_valid_o`=1; it increments `rd_ptr`.
  - `rsp_ack_i` while `rsp_valid_o`=0 is ignored.
- **Count update.**
  - Accepted push and pop in the same cycle: `count` unchanged.
  - Push only: `count`+1.
  - Pop only: `count`-1.
- **Head outputs.**
  - `rsp_valid_o` = (`count` != 0).
  - `rsp_dst_port_mask_o`, `rsp_drop_o` and `rsp_prio_o` = `mem[rd_ptr]`.
  - While `rsp_valid_o`=1 and not acked, these outputs hold stable.
- **Overflow flag.** `ovf_clr_i`=1 clears `ovf_o`. If clear and overflow occur in the same cycle, set wins.
- **Status outputs.** `req_full_o` = (`count` == `g_fifo_depth`). `count_o` = `count`.

## Timing

- **Reset values (asynchronous, immediately on `rst_n_i`=0):**
  - `count`, `rd_ptr`, `wr_ptr` = 0.
  - `rsp_valid_o`=0, `req_full_o`=0, `ovf_o`=0, `count_o`=0.
  - Memory contents are don't-care; head data outputs are 0 because memory is reset.
- **Latency.** A push accepted at edge N gives `rsp_valid_o`=1 and valid head data after edge N (one cycle) when the FIFO was empty.
- **Ack.** Ack sampled at edge N:
  - the next entry is presented after edge N;
  - `rsp_valid_o` falls after edge N if `count` was 1 and there was no push.
- **Back-to-back.** A continuous ack with a non-empty FIFO pops one entry per cycle.
- **Empty with simultaneous push.** With `count`=0, a push and an ack in the same cycle: the ack is ignored, and the entry appears the next cycle.
- **Full/ack interaction.** `req_full_o` deasserts one cycle after the pop that frees a slot. The producer may push in that cycle.
- **Reset mid-operation.** All buffered entries are lost. `rsp_valid_o` drops immediately (asynchronously).

## Test plan

- **Single decision.** Reset, push mask=7'b0000110, drop=0, prio=5.
  - `rsp_valid_o`=1 one cycle later with identical fields.
  - Hold ack low for 10 cycles: outputs stable.
  - Ack 1 cycle: `rsp_valid_o`=0, `count_o`=0.
- **Fill and overflow.** Depth 4, push 5 entries with prio 0..4 and no ack.
  - `req_full_o`=1 after the 4th push; the 5th is rejected and `ovf_o`=1.
  - Ack 4 times: prio 0,1,2,3 are delivered in order; the 5th never appears.
  - Pulse `ovf_clr_i`: `ovf_o`=0.
- **Normalisation.**
  - Push mask=7'h7F, drop=1: head shows mask=0, drop=1.
  - Push mask=0, drop=0: head shows drop=1.
- **Simultaneous push/pop.** With `count`=2, push and ack in the same cycle for 20 cycles.
  - `count_o` stays 2.
  - Pointers wrap at least 4 times.
  - Data order is preserved.
- **Boundary handshakes.**
  - Ack with `rsp_valid_o`=0: `count_o` stays 0, no pointer move.
  - Full plus simultaneous push/ack: the push is rejected, `count_o`=3, `ovf_o`=1.
- **Reset mid-stream.** With 3 entries queued, assert `rst_n_i` low for 1 cycle.
  - `rsp_valid_o`=0 immediately, and `count_o`=0.
  - The next push appears after 1 cycle with correct fields.
